// File: rtl/embeddedinn_vga.sv
// 640x480@60 Hz VGA timing generator with a selectable 2-bit-per-channel test pattern (TinyVGA PMOD pinout).
// Optional VGA_ANIM_EN: a per-frame counter scrolls patterns 00-10 left by one pixel each frame.
module embeddedinn_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h, v, x;
  logic [1:0] mode, r, g, b;
  logic [2:0] bar;
  logic       active, hs, vs, end_of_line, end_of_frame;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign end_of_line  = (h == H_MAX);
  assign end_of_frame = end_of_line && (v == V_MAX);

  // rst_n is an active-high synchronous reset despite its name.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      h <= '0;
      v <= '0;
    end else if (end_of_line) begin
      h <= '0;
      v <= end_of_frame ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

`ifdef VGA_ANIM_EN
  logic [9:0] frame;

  always_ff @(posedge clk) begin
    if (rst_n)             frame <= '0;
    else if (end_of_frame) frame <= frame + 10'd1;
  end

  assign x = h + frame;
`else
  assign x = h;
`endif

  assign mode   = ui_in[1:0];
  assign bar    = x[8:6];
  assign active = (h < H_ACT) && (v < V_ACT);
  assign hs     = !((h >= H_SYNC_LO) && (h < H_SYNC_HI));
  assign vs     = !((v >= V_SYNC_LO) && (v < V_SYNC_HI));

  // NOTE: defaults before the case keep this purely combinational (no latch on r/g/b).
  always_comb begin
    r = 2'b00;
    g = 2'b00;
    b = 2'b00;
    if (active) begin
      case (mode)
        2'b00: begin
          r = {2{bar[2]}};
          g = {2{bar[1]}};
          b = {2{bar[0]}};
        end
        2'b01: begin
          r = {2{x[5] ^ v[5]}};
          g = {2{x[5] ^ v[5]}};
          b = {2{x[5] ^ v[5]}};
        end
        2'b10: begin
          r = x[7:6];
          g = v[7:6];
          b = x[7:6] ^ v[7:6];
        end
        default: begin
          r = ui_in[7:6];
          g = ui_in[5:4];
          b = ui_in[3:2];
        end
      endcase
    end
  end

  // Registering the pin word keeps sync and colour aligned at one clock of latency.
  always_ff @(posedge clk) begin
    if (rst_n) uo_out <= 8'h88;
    else       uo_out <= {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, x};

endmodule

// File: tb/tb_embeddedinn_vga.sv
// Bench for embeddedinn_vga: a full-timing instance checked against a pixel table, plus a
// short-frame instance (15 lines) that makes VS pulses and frame wrap reachable quickly.
module tb_embeddedinn_vga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_s, uio_out_s, uio_oe_s;

  always #20 clk = ~clk;

  embeddedinn_vga dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  embeddedinn_vga #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_s), .uio_out(uio_out_s), .uio_oe(uio_oe_s)
  );

  typedef struct {
    int         h;
    int         v;
    logic [7:0] ui;
    logic [7:0] exp;
    logic       chk_s;
    logic [7:0] exp_s;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   nxt = 0;
  logic mon_en = 1'b0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    nxt++;
  endtask

  task automatic add(input int h, input int v, input logic [7:0] ui, input logic [7:0] exp,
                     input logic chk_s = 1'b0, input logic [7:0] exp_s = 8'h00);
    vec_t e;
    e.h = h; e.v = v; e.ui = ui; e.exp = exp; e.chk_s = chk_s; e.exp_s = exp_s;
    vecs.push_back(e);
  endtask

  // Sync pulse widths and periods: HS on the full instance, VS on the short-frame instance.
  initial begin
    int cyc, hs_cnt, hs_last, vs_cnt, vs_last;
    logic hs_prev, vs_prev;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cyc = 0; hs_cnt = 0; hs_last = -1; vs_cnt = 0; vs_last = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
      end else begin
        cyc++;
        if (!uo_out[7]) begin
          if (hs_prev) begin
            if (hs_last >= 0) check("hs_period", cyc - hs_last, 800);
            hs_last = cyc;
          end
          hs_cnt++;
        end else if (!hs_prev) begin
          check("hs_width", hs_cnt, 96);
          hs_cnt = 0;
        end
        if (!uo_s[3]) begin
          if (vs_prev) begin
            if (vs_last >= 0) check("vs_period", cyc - vs_last, 12000);
            vs_last = cyc;
          end
          vs_cnt++;
        end else if (!vs_prev) begin
          check("vs_width", vs_cnt, 1600);
          vs_cnt = 0;
        end
        hs_prev = uo_out[7];
        vs_prev = uo_s[3];
      end
    end
  end

  initial begin
    // Line 0, colour bars, horizontal blanking and HS edges
    add(0, 0, 8'h00, 8'h88);   add(10, 0, 8'h00, 8'h88);  add(70, 0, 8'h00, 8'hCC);
    add(130, 0, 8'h00, 8'hAA); add(200, 0, 8'h00, 8'hEE); add(260, 0, 8'h00, 8'h99);
    add(480, 0, 8'h00, 8'hFF); add(512, 0, 8'h00, 8'h88); add(639, 0, 8'h00, 8'hCC);
    add(640, 0, 8'h00, 8'h88); add(655, 0, 8'h00, 8'h88); add(656, 0, 8'h00, 8'h08);
    add(751, 0, 8'h00, 8'h08); add(752, 0, 8'h00, 8'h88);
    // Checkerboard
    add(0, 1, 8'h01, 8'h88);   add(32, 1, 8'h01, 8'hFF);  add(64, 1, 8'h01, 8'h88);
    add(700, 1, 8'h01, 8'h08);
    // Gradient
    add(0, 2, 8'h02, 8'h88);   add(64, 2, 8'h02, 8'hD8);  add(128, 2, 8'h02, 8'h8D);
    add(192, 2, 8'h02, 8'hDD); add(256, 2, 8'h02, 8'h88);
    // Solid colour, changed on consecutive pixels
    add(100, 3, 8'hC3, 8'h99); add(101, 3, 8'hFF, 8'hFF); add(102, 3, 8'h1F, 8'hEC);
    add(700, 3, 8'hFF, 8'h08);
    // Short-frame instance: vertical blanking, VS low, wrap into its next frame
    add(70, 8, 8'h00, 8'hCC, 1'b1, 8'h88);
    add(10, 10, 8'h00, 8'h88, 1'b1, 8'h80);  add(70, 10, 8'h00, 8'hCC, 1'b1, 8'h80);
    add(480, 10, 8'h00, 8'hFF, 1'b1, 8'h80); add(700, 10, 8'h00, 8'h08, 1'b1, 8'h00);
`ifdef VGA_ANIM_EN
    add(63, 15, 8'h00, 8'h88, 1'b1, 8'hCC);
`else
    add(63, 15, 8'h00, 8'h88, 1'b1, 8'h88);
`endif
    add(70, 15, 8'h00, 8'hCC, 1'b1, 8'hCC);
    // y[5] and y[7:6] dependence
    add(0, 32, 8'h01, 8'hFF, 1'b1, 8'h88);   add(40, 32, 8'h01, 8'h88, 1'b1, 8'hFF);
    add(0, 64, 8'h02, 8'hE8, 1'b1, 8'h88);   add(64, 64, 8'h02, 8'hB8, 1'b1, 8'hD8);

    // Reset held for 5 clocks
    rst_n = 1'b1;
    repeat (5) step();
    check("reset_uo_out", uo_out, 8'h88);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uo_out_s", uo_s, 8'h88);

    rst_n = 1'b0;
    nxt = 0;
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      while (nxt < vecs[i].v * 800 + vecs[i].h) step();
      ui_in = vecs[i].ui;
      step();
      check($sformatf("px(%0d,%0d)", vecs[i].h, vecs[i].v), uo_out, vecs[i].exp);
      if (vecs[i].chk_s)
        check($sformatf("short_px(%0d,%0d)", vecs[i].h, vecs[i].v), uo_s, vecs[i].exp_s);
    end
    check("uio_out_run", uio_out, 8'h00);
    check("uio_oe_run", uio_oe, 8'h00);

    // Reset mid-frame: outputs idle, then restart from pixel (0,0)
    mon_en = 1'b0;
    ui_in = 8'h00;
    rst_n = 1'b1;
    repeat (3) step();
    check("midreset_uo_out", uo_out, 8'h88);
    check("midreset_uo_out_s", uo_s, 8'h88);
    check("midreset_uio_out", uio_out, 8'h00);
    check("midreset_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b0;
    nxt = 0;
    step();
    check("restart_px(0,0)", uo_out, 8'h88);
    while (nxt < 70) step();
    step();
    check("restart_px(70,0)", uo_out, 8'hCC);
    check("restart_short_px(70,0)", uo_s, 8'hCC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
